// File: rtl/i2c_master_writer_pkg.sv
// Shared encodings for the I2C master family: FSM states, quarter-period indices, R/W bit.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        STOP,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quarter_e;

    localparam logic RW_WRITE = 1'b0;

    // States whose Q1->Q2 step must wait for SCL to read back high (clock stretching)
    function automatic logic waits_for_scl(input state_e s);
        return (s == ADDR) || (s == ADDR_ACK) || (s == DATA) ||
               (s == DATA_ACK) || (s == STOP);
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period divider: one-cycle qtick every DIV clocks while enabled.
// Latency: qtick is combinational from the counter, DIV clocks after enable rises.
// Backpressure: hold parks the counter at terminal count (no qtick) until released.
module i2c_quarter_tick #(
    parameter int DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic enable,
    input  logic hold,
    output logic qtick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          at_tc;

    assign at_tc = (cnt_q == CW'(DIV - 1));
    assign qtick = enable && at_tc && !hold;

    // Count 0..DIV-1; parked at 0 when disabled, frozen at terminal count while held
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (!enable) begin
            cnt_q <= '0;
        end else if (at_tc) begin
            if (!hold) begin
                cnt_q <= '0;
            end
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_writer.sv
// Single-byte I2C write master: START, address+W, one data byte, STOP, ACK checked per byte.
// Latency: 22 x 4 x DIV clocks for an ACKed address (13 x 4 x DIV on address NACK) plus one DONE clock; SCL stretching adds to it.
// Backpressure: start is taken only in IDLE; requests while busy or during the DONE cycle are dropped, not queued.
module i2c_master_writer
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int I2C_FREQ_HZ = 100_000,
    parameter int DIV         = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ)
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [6:0] slave_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    inout  wire        i2c_sda,
    inout  wire        i2c_scl
);

    if (DIV < 2) begin : g_div_check
        $error("i2c_master_writer: DIV must be at least 2");
    end

    state_e     state_q;
    quarter_e   quarter_q;
    logic       guard_q;     // first/second pass of START and STOP (bus-free cell)
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] data_q;
    logic       sda_low_q;
    logic       scl_low_q;
    logic       busy_q;
    logic       done_q;
    logic       ack_err_q;
    logic       scl_s1_q, scl_s2_q;
    logic       sda_s1_q, sda_s2_q;

    logic       tick_en;
    logic       tick_hold;
    logic       qtick;

    // Open-drain pads: only ever pull low or let go
    assign i2c_sda   = sda_low_q ? 1'b0 : 1'bz;
    assign i2c_scl   = scl_low_q ? 1'b0 : 1'bz;

    assign busy      = busy_q;
    assign done      = done_q;
    assign ack_error = ack_err_q;

    assign tick_en   = (state_q != IDLE) && (state_q != DONE);
    assign tick_hold = (quarter_q == Q1) && waits_for_scl(state_q) && !scl_s2_q;

    i2c_quarter_tick #(
        .DIV (DIV)
    ) u_qtick (
        .CLK    (CLK),
        .RST    (RST),
        .enable (tick_en),
        .hold   (tick_hold),
        .qtick  (qtick)
    );

    // Two-flop synchronisers for the bus lines; idle bus reads high
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= i2c_scl;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= i2c_sda;
            sda_s2_q <= sda_s1_q;
        end
    end

    // Transfer FSM: each qtick ends the current quarter and sets the pad levels for the next one.
    // START runs an idle bus-free pass before the START condition; STOP runs one after it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            quarter_q <= Q0;
            guard_q   <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            sda_low_q <= 1'b0;
            scl_low_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q   <= {slave_addr, RW_WRITE};
                        data_q    <= wr_data;
                        ack_err_q <= 1'b0;
                        busy_q    <= 1'b1;
                        guard_q   <= 1'b1;
                        quarter_q <= Q0;
                        state_q   <= START;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    if (qtick) begin
                        quarter_q <= quarter_e'(quarter_q + 2'd1);
                        case (quarter_q)
                            Q0: begin
                                if (state_q != START && !guard_q) begin
                                    scl_low_q <= 1'b0;
                                end
                            end
                            Q1: begin
                                if (!guard_q) begin
                                    if (state_q == START) begin
                                        sda_low_q <= 1'b1;
                                    end else if (state_q == STOP) begin
                                        sda_low_q <= 1'b0;
                                    end
                                end
                            end
                            Q2: begin
                                if (state_q == START && !guard_q) begin
                                    scl_low_q <= 1'b1;
                                end else if ((state_q == ADDR_ACK || state_q == DATA_ACK) && sda_s2_q) begin
                                    ack_err_q <= 1'b1;
                                end
                            end
                            Q3: begin
                                case (state_q)
                                    START: begin
                                        if (guard_q) begin
                                            guard_q <= 1'b0;
                                        end else begin
                                            state_q   <= ADDR;
                                            bit_cnt_q <= 3'd7;
                                            sda_low_q <= ~shift_q[7];
                                        end
                                    end
                                    ADDR, DATA: begin
                                        scl_low_q <= 1'b1;
                                        if (bit_cnt_q == 3'd0) begin
                                            state_q   <= (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
                                            sda_low_q <= 1'b0;
                                        end else begin
                                            bit_cnt_q <= bit_cnt_q - 3'd1;
                                            shift_q   <= {shift_q[6:0], 1'b0};
                                            sda_low_q <= ~shift_q[6];
                                        end
                                    end
                                    ADDR_ACK: begin
                                        scl_low_q <= 1'b1;
                                        if (ack_err_q) begin
                                            sda_low_q <= 1'b1;
                                            state_q   <= STOP;
                                        end else begin
                                            shift_q   <= data_q;
                                            bit_cnt_q <= 3'd7;
                                            sda_low_q <= ~data_q[7];
                                            state_q   <= DATA;
                                        end
                                    end
                                    DATA_ACK: begin
                                        scl_low_q <= 1'b1;
                                        sda_low_q <= 1'b1;
                                        state_q   <= STOP;
                                    end
                                    STOP: begin
                                        if (!guard_q) begin
                                            guard_q <= 1'b1;
                                        end else begin
                                            guard_q <= 1'b0;
                                            busy_q  <= 1'b0;
                                            done_q  <= 1'b1;
                                            state_q <= DONE;
                                        end
                                    end
                                    default: begin
                                        state_q <= IDLE;
                                    end
                                endcase
                            end
                            default: begin
                                quarter_q <= Q0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
